// File: rtl/ssp_param.sv
// Parametrised synchronous serial port: bus-side TX/RX FIFOs, framed serial TX and RX, sticky RX overrun.
// Define SSP_LOOPBACK_EN to add the LBM input that routes the transmitter into the receiver internally.

module ssp_param_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module ssp_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 1
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
`ifdef SSP_LOOPBACK_EN
    input  logic              LBM,
`endif
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              SSPTXINTR,
    output logic              SSPRXINTR,
    output logic              SSPRXOVR,
    output logic [1:0]        tx_state,
    output logic              rx_state
);
    typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_DATA} tx_state_e;
    typedef enum logic       {RX_IDLE, RX_RECV} rx_state_e;

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(DATA_W);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BITS_ONE  = BW'(1);

    // Bus handshake: a transfer happens on every PCLK edge with PSEL=1 (no wait states);
    // PWRITE=1 pushes PWDATA into TX, PWRITE=0 pops the RX head shown on PRDATA.
    logic bus_write;
    logic bus_read;
    assign bus_write = PSEL && PWRITE;
    assign bus_read  = PSEL && !PWRITE;

    logic [DW-1:0] div_cnt;
    logic          clk_out_q;
    logic          div_wrap;
    logic          tick;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign tick     = div_wrap && !clk_out_q;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            div_cnt   <= '0;
            clk_out_q <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            clk_out_q <= !clk_out_q;
        end else begin
            div_cnt   <= div_cnt + DIV_ONE;
        end
    end

    logic [DATA_W-1:0] tx_head;
    logic              tx_empty;
    logic              tx_full;
    logic              tx_pop;
    tx_state_e         tx_st;
    logic [DATA_W-1:0] tx_shift;
    logic [BW-1:0]     tx_bits;
    logic              fss_q;
    logic              txd_q;
    logic              oe_b_q;

    ssp_param_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (PCLK),
        .rst_n     (CLEAR_B),
        .push      (bus_write),
        .push_data (PWDATA),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    // The FSM takes a new word either from IDLE or right after the last data bit of the current word.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_st == TX_IDLE) || (tx_st == TX_DATA && tx_bits == BITS_ALL));

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            tx_st    <= TX_IDLE;
            tx_shift <= '0;
            tx_bits  <= '0;
            fss_q    <= 1'b0;
            txd_q    <= 1'b0;
            oe_b_q   <= 1'b1;
        end else if (tick) begin
            case (tx_st)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        fss_q    <= 1'b1;
                        tx_st    <= TX_FRAME;
                    end else begin
                        fss_q    <= 1'b0;
                        oe_b_q   <= 1'b1;
                    end
                end
                TX_FRAME: begin
                    fss_q    <= 1'b0;
                    oe_b_q   <= 1'b0;
                    txd_q    <= tx_shift[DATA_W-1];
                    tx_shift <= tx_shift << 1;
                    tx_bits  <= BITS_ONE;
                    tx_st    <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bits == BITS_ALL) begin
                        oe_b_q <= 1'b1;
                        txd_q  <= 1'b0;
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            fss_q    <= 1'b1;
                            tx_st    <= TX_FRAME;
                        end else begin
                            tx_st    <= TX_IDLE;
                        end
                    end else begin
                        txd_q    <= tx_shift[DATA_W-1];
                        tx_shift <= tx_shift << 1;
                        tx_bits  <= tx_bits + BITS_ONE;
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    logic rx_clk;
    logic rx_fss;
    logic rx_dat;

`ifdef SSP_LOOPBACK_EN
    assign rx_clk  = LBM ? clk_out_q : SSPCLKIN;
    assign rx_fss  = LBM ? fss_q     : SSPFSSIN;
    assign rx_dat  = LBM ? txd_q     : SSPRXD;
    assign SSPOE_B = oe_b_q | LBM;
`else
    assign rx_clk  = SSPCLKIN;
    assign rx_fss  = SSPFSSIN;
    assign rx_dat  = SSPRXD;
    assign SSPOE_B = oe_b_q;
`endif

    logic              rx_clk_q;
    logic              rx_fall;
    rx_state_e         rx_st;
    logic [DATA_W-1:0] rx_shift;
    logic [BW-1:0]     rx_bits;
    logic              rx_valid;
    logic              rx_drop;
    logic              ovr_q;
    logic [DATA_W-1:0] rx_head;
    logic              rx_empty;
    logic              rx_full;

    assign rx_fall = rx_clk_q && !rx_clk;
    // A full RX FIFO only loses the word when the bus is not popping in the same cycle.
    assign rx_drop = rx_valid && rx_full && !bus_read;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rx_clk_q <= 1'b0;
            rx_st    <= RX_IDLE;
            rx_shift <= '0;
            rx_bits  <= '0;
            rx_valid <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            rx_clk_q <= rx_clk;
            rx_valid <= 1'b0;
            if (rx_drop) ovr_q <= 1'b1;
            if (rx_fall) begin
                case (rx_st)
                    RX_IDLE: begin
                        if (rx_fss) begin
                            rx_st   <= RX_RECV;
                            rx_bits <= '0;
                        end
                    end
                    RX_RECV: begin
                        rx_shift <= {rx_shift[DATA_W-2:0], rx_dat};
                        if (rx_bits == BITS_LAST) begin
                            rx_valid <= 1'b1;
                            rx_st    <= RX_IDLE;
                        end else begin
                            rx_bits  <= rx_bits + BITS_ONE;
                        end
                    end
                    default: rx_st <= RX_IDLE;
                endcase
            end
        end
    end

    ssp_param_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (PCLK),
        .rst_n     (CLEAR_B),
        .push      (rx_valid),
        .push_data (rx_shift),
        .pop       (bus_read),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign PRDATA    = rx_empty ? '0 : rx_head;
    assign SSPCLKOUT = clk_out_q;
    assign SSPFSSOUT = fss_q;
    assign SSPTXD    = txd_q;
    assign SSPTXINTR = tx_full;
    assign SSPRXINTR = rx_full;
    assign SSPRXOVR  = ovr_q;
    assign tx_state  = tx_st;
    assign rx_state  = rx_st;
endmodule

// File: tb/tb_ssp_param.sv
// Directed bench for ssp_param (8-bit, 4-deep, CLK_DIV=1) with the serial outputs wired back to the inputs.
// Covers SSP_LOOPBACK_EN when that macro is defined for the build.

module tb_ssp_param;
    localparam int W = 8;

    logic         PCLK    = 1'b0;
    logic         CLEAR_B = 1'b1;
    logic         PSEL    = 1'b0;
    logic         PWRITE  = 1'b0;
    logic [W-1:0] PWDATA  = '0;
    logic [W-1:0] PRDATA;
    logic         SSPCLKOUT;
    logic         SSPFSSOUT;
    logic         SSPTXD;
    logic         SSPOE_B;
    logic         SSPTXINTR;
    logic         SSPRXINTR;
    logic         SSPRXOVR;
    logic [1:0]   tx_state;
    logic         rx_state;
    logic         ext_cut = 1'b0;
    logic         clk_in;
    logic         fss_in;
    logic         rxd_in;
`ifdef SSP_LOOPBACK_EN
    logic         LBM = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;
    logic fss_prev = 1'b0;

    assign clk_in = ext_cut ? 1'b0 : SSPCLKOUT;
    assign fss_in = ext_cut ? 1'b0 : SSPFSSOUT;
    assign rxd_in = ext_cut ? 1'b0 : SSPTXD;

    ssp_param #(.DATA_W(W), .FIFO_DEPTH(4), .CLK_DIV(1)) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPCLKIN  (clk_in),
        .SSPFSSIN  (fss_in),
        .SSPRXD    (rxd_in),
`ifdef SSP_LOOPBACK_EN
        .LBM       (LBM),
`endif
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR),
        .SSPRXOVR  (SSPRXOVR),
        .tx_state  (tx_state),
        .rx_state  (rx_state)
    );

    always #5 PCLK = ~PCLK;

    // Counts rising edges of the transmit frame pulse.
    always @(negedge PCLK) begin
        fss_prev <= SSPFSSOUT;
        if (SSPFSSOUT && !fss_prev) frames <= frames + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [W-1:0] d);
        @(negedge PCLK);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = d;
        @(posedge PCLK);
        #1;
        PSEL   = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [W-1:0] exp);
        @(negedge PCLK);
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        #1;
        check(tag, PRDATA, exp);
        @(posedge PCLK);
        #1;
        PSEL   = 1'b0;
    endtask

    task automatic wait_fss(input string tag, input int max_cyc);
        int found = 0;
        for (int i = 0; i < max_cyc && found == 0; i++) begin
            @(negedge PCLK);
            if (SSPFSSOUT) found = 1;
        end
        check(tag, found, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clkout"}, SSPCLKOUT, 0);
        check({tag, "_fss"}, SSPFSSOUT, 0);
        check({tag, "_txd"}, SSPTXD, 0);
        check({tag, "_oe_b"}, SSPOE_B, 1);
        check({tag, "_rxovr"}, SSPRXOVR, 0);
        check({tag, "_prdata"}, PRDATA, 0);
        check({tag, "_txintr"}, SSPTXINTR, 0);
        check({tag, "_rxintr"}, SSPRXINTR, 0);
        check({tag, "_tx_state"}, tx_state, 0);
        check({tag, "_rx_state"}, rx_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic         prev_clk;
        int           f0;
        int           seen;
        int           oe_low;

        // Reset, then 20 idle cycles.
        #2 CLEAR_B = 1'b0;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        CLEAR_B  = 1'b1;
        prev_clk = SSPCLKOUT;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            check("idle_clk_toggle", SSPCLKOUT, !prev_clk);
            prev_clk = SSPCLKOUT;
            check("idle_oe_b", SSPOE_B, 1);
            check("idle_fss", SSPFSSOUT, 0);
            check("idle_txintr", SSPTXINTR, 0);
            check("idle_rxintr", SSPRXINTR, 0);
            check("idle_prdata", PRDATA, 0);
        end

        // Single word 0xA5 through the wire loop.
        write_word(8'hA5);
        wait_fss("a5_fss_seen", 20);
        @(negedge PCLK);
        check("a5_fss_cycle2", SSPFSSOUT, 1);
        @(negedge PCLK);
        check("a5_fss_low", SSPFSSOUT, 0);
        w = 8'hA5;
        for (int i = 0; i < W; i++) begin
            check("a5_txd", SSPTXD, w[W-1-i]);
            check("a5_oe_b", SSPOE_B, 0);
            @(negedge PCLK);
            @(negedge PCLK);
        end
        check("a5_end_oe_b", SSPOE_B, 1);
        check("a5_end_txd", SSPTXD, 0);
        repeat (4) @(negedge PCLK);
        read_check("a5_rx", 8'hA5);
        check("a5_rx_empty", PRDATA, 0);

        // Burst of five writes while a primer word 0xC3 is being shifted out.
        f0 = frames;
        write_word(8'hC3);
        wait_fss("burst_primer_fss", 20);
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        check("burst_txintr_3", SSPTXINTR, 0);
        write_word(8'h44);
        check("burst_txintr_4", SSPTXINTR, 1);
        write_word(8'h55);
        check("burst_txintr_drop", SSPTXINTR, 1);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge PCLK);
            if (PRDATA != '0) seen = 1;
        end
        check("burst_primer_arrived", seen, 1);
        read_check("burst_primer_rx", 8'hC3);
        repeat (100) @(negedge PCLK);
        check("burst_frames", frames - f0, 5);
        check("burst_rxintr", SSPRXINTR, 1);
        read_check("burst_rx0", 8'h11);
        read_check("burst_rx1", 8'h22);
        read_check("burst_rx2", 8'h33);
        read_check("burst_rx3", 8'h44);
        check("burst_rx_empty", PRDATA, 0);
        check("burst_no_ovr", SSPRXOVR, 0);

        // Five words received with no reads: full after four, overrun on the fifth.
        for (int i = 1; i <= 5; i++) write_word(8'(i));
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge PCLK);
            if (SSPRXINTR) seen = 1;
        end
        check("ovr_rxintr_seen", seen, 1);
        check("ovr_not_yet", SSPRXOVR, 0);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge PCLK);
            if (SSPRXOVR) seen = 1;
        end
        check("ovr_set", seen, 1);
        check("ovr_rxintr_hold", SSPRXINTR, 1);
        read_check("ovr_rx0", 8'h01);
        read_check("ovr_rx1", 8'h02);
        read_check("ovr_rx2", 8'h03);
        read_check("ovr_rx3", 8'h04);
        check("ovr_rx_empty", PRDATA, 0);
        check("ovr_sticky", SSPRXOVR, 1);

        // Reset in the middle of 0xFF, then a clean 0x3C.
        write_word(8'hFF);
        wait_fss("rst_fss_seen", 20);
        repeat (6) @(negedge PCLK);
        check("rst_mid_oe_b", SSPOE_B, 0);
        check("rst_mid_txd", SSPTXD, 1);
        CLEAR_B = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge PCLK);
        CLEAR_B = 1'b1;
        repeat (40) @(negedge PCLK);
        check("rst_no_push", PRDATA, 0);
        check("rst_no_push_intr", SSPRXINTR, 0);
        check("rst_no_ovr", SSPRXOVR, 0);
        write_word(8'h3C);
        wait_fss("post_rst_fss", 20);
        repeat (25) @(negedge PCLK);
        read_check("post_rst_rx", 8'h3C);
        check("post_rst_empty", PRDATA, 0);

`ifdef SSP_LOOPBACK_EN
        // Internal loopback with the external receive pins held low.
        LBM     = 1'b1;
        ext_cut = 1'b1;
        @(negedge PCLK);
        check("lb_oe_b", SSPOE_B, 1);
        write_word(8'h96);
        oe_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (!SSPOE_B) oe_low++;
        end
        check("lb_oe_held", oe_low, 0);
        read_check("lb_rx", 8'h96);
        check("lb_empty", PRDATA, 0);
        LBM     = 1'b0;
        ext_cut = 1'b0;
`else
        oe_low = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ssp_param.md
Name: ssp_param

Overview:
Parametrised next-generation Synchronous Serial Port. It has configurable word width, FIFO depth and serial clock divider, and adds RX overrun detection. The bus side writes words into an internal TX FIFO and reads words from an internal RX FIFO. A transmit FSM serialises TX words onto SSPTXD with a frame pulse. A receive FSM deserialises SSPRXD into the RX FIFO. It replaces the fixed 8-bit, 4-deep SSP at the top level of the serial subsystem.

Parameters:
DATA_W, 8, word width in bits (2..32).
FIFO_DEPTH, 4, entries per FIFO (power of 2, >=2).
CLK_DIV, 1, PCLK cycles per SSPCLKOUT half-period (>=1).

Ports:
PCLK  in  1  single clock; all logic on rising edge.
CLEAR_B  in  1  asynchronous active-low reset.
PSEL  in  1  bus select.
PWRITE  in  1  1 = write TX FIFO, 0 = read RX FIFO.
PWDATA  in  DATA_W  word to transmit.
PRDATA  out  DATA_W  RX FIFO head word.
SSPCLKIN  in  1  receive serial clock.
SSPFSSIN  in  1  receive frame pulse.
SSPRXD  in  1  serial data in.
SSPCLKOUT  out  1  transmit serial clock.
SSPFSSOUT  out  1  transmit frame pulse.
SSPTXD  out  1  serial data out.
SSPOE_B  out  1  active-low TX data enable.
SSPTXINTR  out  1  TX FIFO full.
SSPRXINTR  out  1  RX FIFO full.
SSPRXOVR  out  1  sticky RX overrun flag.

Behaviour:
- Reset (CLEAR_B low, async): both FIFOs empty; FSMs go to IDLE; clock divider cleared. Outputs: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, SSPRXOVR=0, PRDATA=0.
- Reset asserted mid-frame aborts the frame immediately. No partial word is pushed.
- Bus write (PSEL=1, PWRITE=1): pushes PWDATA at the PCLK edge. If the TX FIFO is full, the word is dropped and the FIFO is unchanged.
- Bus read (PSEL=1, PWRITE=0): PRDATA shows the head combinationally (show-ahead). The head is popped at the same edge. When the FIFO is empty, PRDATA=0 and no pop occurs.
- A simultaneous push and pop on one FIFO in the same cycle is legal. The count is unchanged, and a pop with push on a full FIFO succeeds.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- SSPTXINTR = TX count==FIFO_DEPTH. SSPRXINTR = RX count==FIFO_DEPTH. Both are combinational from registered counts.
- SSPCLKOUT free-runs from reset and toggles every CLK_DIV PCLK cycles. tick = the PCLK edge on which SSPCLKOUT goes 0->1.
- TX FSM advances only on tick:
  - IDLE: if the TX FIFO is non-empty, pop into the shift register, set SSPFSSOUT=1, go to FRAME. Otherwise hold SSPOE_B=1 and SSPFSSOUT=0.
  - FRAME (one SSPCLKOUT period): set SSPFSSOUT=0, SSPOE_B=0, SSPTXD=shift MSB, go to DATA with bit count 1.
  - DATA: shift left and drive the next MSB. After DATA_W bits have been driven, on the next tick: if the TX FIFO is non-empty, pop, assert SSPFSSOUT, set SSPOE_B=1 and go to FRAME (back-to-back words with one frame period between them). Otherwise set SSPOE_B=1, SSPTXD=0 and go to IDLE.
  - A pop by the TX FSM coinciding with a bus push is handled as a simultaneous push/pop.
- RX side:
  - SSPCLKIN is registered each PCLK. A falling edge is detected as prev=1 and cur=0, using the raw input. This implies 1 PCLK detection latency.
  - RX IDLE: on a falling edge with SSPFSSIN=1, go to RECV with bit count 0.
  - RECV: on each falling edge, shift SSPRXD in at the LSB, MSB first.
  - On the DATA_W-th bit, the assembled word is pushed to the RX FIFO on the following PCLK edge, and the FSM returns to IDLE. It may immediately re-frame on the next falling edge.
  - If the RX FIFO is full at push time (after accounting for a same-cycle bus pop), the word is dropped and SSPRXOVR sets.
  - SSPRXOVR clears only on reset.

Optional Feature:
Macro SSP_LOOPBACK_EN.
- Defined: an extra input port LBM (1 bit) is present. When LBM=1, the receiver uses SSPCLKOUT, SSPFSSOUT and SSPTXD internally in place of SSPCLKIN, SSPFSSIN and SSPRXD, and SSPOE_B is held 1.
- Not defined: no LBM port and no mux; the external receive pins are always used.

Test Plan:
All scenarios use DATA_W=8, FIFO_DEPTH=4, CLK_DIV=1, with SSPCLKOUT/SSPFSSOUT/SSPTXD externally wired to SSPCLKIN/SSPFSSIN/SSPRXD.
- Reset then idle -> SSPOE_B=1, SSPFSSOUT=0, SSPTXINTR=0, SSPRXINTR=0 and PRDATA=0 for 20 cycles, while SSPCLKOUT toggles every PCLK.
- Write 0xA5 -> SSPFSSOUT high for 2 PCLK, then SSPTXD carries 1,0,1,0,0,1,0,1 with SSPOE_B=0. The RX FIFO then holds 0xA5, and a read returns 0xA5 with the FIFO empty afterwards.
- Write 0x11,0x22,0x33,0x44,0x55 in consecutive cycles -> SSPTXINTR=1 after the 4th write and 0x55 is dropped. Exactly 4 frames are sent back-to-back and RX receives 0x11..0x44 in order.
- Receive 5 words without reading -> SSPRXINTR=1 after the 4th word. SSPRXOVR=1 after the 5th. Reads return the first 4 words.
- Pull CLEAR_B low mid-DATA of 0xFF -> all outputs are at reset values within the same cycle and no RX push occurs. A post-reset 0x3C is then transferred correctly.
- SSP_LOOPBACK_EN, LBM=1, external SSPRXD tied 0 -> writing 0x96 yields RX 0x96 while SSPOE_B stays 1.
